// File: rtl/bram_seq_ctrl.sv
// Two-port byte-serial BRAM sequencer.
// Requesters A and B share a byte-wide BRAM; each granted access is split
// into 1, 2 or 4 single-byte BRAM cycles, and reads are reassembled
// little-endian with optional sign extension.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and latches the winner
// ISSUE | one BRAM byte access per cycle, byte index 0..N-1
// DRAIN | reads only: collect the last registered BRAM byte
// DONE  | one-cycle ACK (and ERR for misaligned) to the granted port
module bram_seq_ctrl #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  A_REQ,
  input  logic                  A_WE,
  input  logic                  A_SIGNED,
  input  logic [1:0]            A_SIZE,
  input  logic [ADDR_WIDTH-3:0] A_ADDR,
  input  logic [31:0]           A_WDATA,
  output logic                  A_ACK,
  output logic                  A_ERR,
  output logic [31:0]           A_RDATA,
  input  logic                  B_REQ,
  input  logic                  B_WE,
  input  logic                  B_SIGNED,
  input  logic [1:0]            B_SIZE,
  input  logic [ADDR_WIDTH-3:0] B_ADDR,
  input  logic [31:0]           B_WDATA,
  output logic                  B_ACK,
  output logic                  B_ERR,
  output logic [31:0]           B_RDATA,
  output logic [ADDR_WIDTH-3:0] W_ADDR,
  output logic [ADDR_WIDTH-3:0] R_ADDR,
  output logic                  WRITE_EN,
  output logic                  READ_EN,
  output logic [7:0]            DIN,
  input  logic [7:0]            DOUT
);

  localparam int AW = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state, state_nxt;

  // latched request of the current grant
  logic            gnt_b;
  logic            last_b;
  logic            we_q;
  logic            sgn_q;
  logic [1:0]      sz_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic            err_q;
  logic [1:0]      idx;
  logic [31:0]     rbuf;
  logic [31:0]     rdata_a, rdata_b;

  // arbitration and winner field mux
  logic            any_req, pick_b;
  logic            req_we, req_sgn, req_mis;
  logic [1:0]      req_sz;
  logic [AW-1:0]   req_addr;
  logic [31:0]     req_wdata;
  logic [1:0]      last_idx;
  logic [1:0]      idx_m1;
  logic [AW-1:0]   acc_addr;
  logic [31:0]     rd_full, rd_ext;

  // Round-robin: on a tie the port not granted last time wins.
  always_comb begin
    any_req   = A_REQ | B_REQ;
    pick_b    = B_REQ & (~A_REQ | ~last_b);
    req_we    = pick_b ? B_WE     : A_WE;
    req_sgn   = pick_b ? B_SIGNED : A_SIGNED;
    req_addr  = pick_b ? B_ADDR   : A_ADDR;
    req_wdata = pick_b ? B_WDATA  : A_WDATA;
    req_sz    = pick_b ? B_SIZE   : A_SIZE;
    if (req_sz == 2'd3) req_sz = 2'd2;
    req_mis   = ((req_sz == 2'd1) && req_addr[0]) ||
                ((req_sz == 2'd2) && (req_addr[1:0] != 2'b00));
  end

  // Byte bookkeeping and read-data assembly with DOUT as the final byte.
  always_comb begin
    last_idx = (sz_q == 2'd0) ? 2'd0 : (sz_q == 2'd1) ? 2'd1 : 2'd3;
    idx_m1   = idx - 2'd1;
    acc_addr = addr_q + AW'(idx);
    rd_full  = rbuf;
    case (sz_q)
      2'd0:    rd_full[7:0]   = DOUT;
      2'd1:    rd_full[15:8]  = DOUT;
      default: rd_full[31:24] = DOUT;
    endcase
    case (sz_q)
      2'd0:    rd_ext = {{24{sgn_q & rd_full[7]}},  rd_full[7:0]};
      2'd1:    rd_ext = {{16{sgn_q & rd_full[15]}}, rd_full[15:0]};
      default: rd_ext = rd_full;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and strobe/ACK decode; strobes only exist in ISSUE.
  always_comb begin
    state_nxt = state;
    WRITE_EN  = 1'b0;
    READ_EN   = 1'b0;
    W_ADDR    = '0;
    R_ADDR    = '0;
    DIN       = 8'h00;
    A_ACK     = 1'b0;
    B_ACK     = 1'b0;
    A_ERR     = 1'b0;
    B_ERR     = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = req_mis ? DONE : ISSUE;
      end
      ISSUE: begin
        if (we_q) begin
          WRITE_EN = 1'b1;
          W_ADDR   = acc_addr;
          DIN      = wdata_q[{idx, 3'b000} +: 8];
        end else begin
          READ_EN  = 1'b1;
          R_ADDR   = acc_addr;
        end
        if (idx == last_idx) state_nxt = we_q ? DONE : DRAIN;
      end
      DRAIN: state_nxt = DONE;
      DONE: begin
        A_ACK     = ~gnt_b;
        B_ACK     = gnt_b;
        A_ERR     = ~gnt_b & err_q;
        B_ERR     = gnt_b & err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, byte capture and per-port read data update on entering DONE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_b  <= 1'b1;
      gnt_b   <= 1'b0;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      sz_q    <= 2'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      idx     <= 2'd0;
      rbuf    <= 32'h0;
      rdata_a <= 32'h0;
      rdata_b <= 32'h0;
    end else begin
      if (state == IDLE && any_req) begin
        gnt_b   <= pick_b;
        last_b  <= pick_b;
        we_q    <= req_we;
        sgn_q   <= req_sgn;
        sz_q    <= req_sz;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= req_mis;
        idx     <= 2'd0;
        rbuf    <= 32'h0;
      end
      if (state == ISSUE) begin
        idx <= idx + 2'd1;
        if (!we_q && idx != 2'd0) rbuf[{idx_m1, 3'b000} +: 8] <= DOUT;
      end
      // misaligned and write completions return zero; reads return rd_ext
      if (state != DONE && state_nxt == DONE) begin
        if ((state == IDLE) ? pick_b : gnt_b)
          rdata_b <= (state == DRAIN) ? rd_ext : 32'h0;
        else
          rdata_a <= (state == DRAIN) ? rd_ext : 32'h0;
      end
    end
  end

  assign A_RDATA = rdata_a;
  assign B_RDATA = rdata_b;

endmodule

// File: tb/tb_bram_seq_ctrl.sv
// Directed bench for bram_seq_ctrl with a 64-byte registered BRAM model.
module tb_bram_seq_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        A_REQ = 0, A_WE = 0, A_SIGNED = 0;
  logic [1:0]  A_SIZE = 0;
  logic [5:0]  A_ADDR = 0;
  logic [31:0] A_WDATA = 0;
  logic        A_ACK, A_ERR;
  logic [31:0] A_RDATA;
  logic        B_REQ = 0, B_WE = 0, B_SIGNED = 0;
  logic [1:0]  B_SIZE = 0;
  logic [5:0]  B_ADDR = 0;
  logic [31:0] B_WDATA = 0;
  logic        B_ACK, B_ERR;
  logic [31:0] B_RDATA;
  logic [5:0]  W_ADDR, R_ADDR;
  logic        WRITE_EN, READ_EN;
  logic [7:0]  DIN;
  logic [7:0]  DOUT = 8'h00;

  logic [7:0]  mem [64];
  int          n_cmp = 0;
  int          n_err = 0;
  int          viol = 0;
  int          strobe_cnt = 0;

  bram_seq_ctrl #(.ADDR_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_SIGNED(A_SIGNED), .A_SIZE(A_SIZE),
    .A_ADDR(A_ADDR), .A_WDATA(A_WDATA), .A_ACK(A_ACK), .A_ERR(A_ERR), .A_RDATA(A_RDATA),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_SIGNED(B_SIGNED), .B_SIZE(B_SIZE),
    .B_ADDR(B_ADDR), .B_WDATA(B_WDATA), .B_ACK(B_ACK), .B_ERR(B_ERR), .B_RDATA(B_RDATA),
    .W_ADDR(W_ADDR), .R_ADDR(R_ADDR), .WRITE_EN(WRITE_EN), .READ_EN(READ_EN),
    .DIN(DIN), .DOUT(DOUT)
  );

  always #5 CLK = ~CLK;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[8] = 8'h5A;
    mem[9] = 8'hC3;
  end

  always @(posedge CLK) begin
    if (WRITE_EN) mem[W_ADDR] <= DIN;
    if (READ_EN)  DOUT <= mem[R_ADDR];
  end

  // strobe exclusivity, idle-zero addresses/data, single-port ACK
  always @(negedge CLK) begin
    if (!RST) begin
      if (WRITE_EN && READ_EN) viol++;
      if (!WRITE_EN && (W_ADDR != 6'd0 || DIN != 8'h00)) viol++;
      if (!READ_EN && R_ADDR != 6'd0) viol++;
      if (A_ACK && B_ACK) viol++;
      if (WRITE_EN || READ_EN) strobe_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output int k);
    k = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge CLK);
      if (A_ACK || B_ACK) begin
        k = j;
        break;
      end
    end
  endtask

  // one complete transaction from the IDLE negedge; ends at the next IDLE negedge
  task automatic xact(input string tag, input bit port_b, input bit we, input bit sgn,
                      input logic [1:0] size, input logic [5:0] addr, input logic [31:0] wdata,
                      input int exp_lat, input logic [31:0] exp_rd, input bit exp_err,
                      input int exp_strb);
    int k, s0;
    logic [31:0] rd;
    s0 = strobe_cnt;
    if (port_b) begin
      B_WE = we; B_SIGNED = sgn; B_SIZE = size; B_ADDR = addr; B_WDATA = wdata; B_REQ = 1;
    end else begin
      A_WE = we; A_SIGNED = sgn; A_SIZE = size; A_ADDR = addr; A_WDATA = wdata; A_REQ = 1;
    end
    k = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge CLK);
      if (port_b ? B_ACK : A_ACK) begin
        k = j;
        break;
      end
    end
    rd = port_b ? B_RDATA : A_RDATA;
    chk({tag, "_lat"}, k, exp_lat);
    chk({tag, "_err"}, port_b ? B_ERR : A_ERR, exp_err);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_other_ack"}, port_b ? A_ACK : B_ACK, 0);
    A_REQ = 0;
    B_REQ = 0;
    @(negedge CLK);
    chk({tag, "_hold"}, port_b ? B_RDATA : A_RDATA, rd);
    chk({tag, "_strobes"}, strobe_cnt - s0, exp_strb);
  endtask

  initial begin
    int k;
    logic [31:0] a_prev;
    bit ack_seen;

    repeat (3) @(negedge CLK);
    chk("rst_a_ack", A_ACK, 0);
    chk("rst_b_ack", B_ACK, 0);
    chk("rst_a_rdata", A_RDATA, 0);
    chk("rst_strobes", {WRITE_EN, READ_EN}, 0);
    RST = 0;
    @(negedge CLK);

    // tie from reset: A, then B (A re-requests in its ACK cycle), then A
    A_WE = 0; A_SIGNED = 0; A_SIZE = 0; A_ADDR = 6'h08; A_REQ = 1;
    B_WE = 0; B_SIGNED = 1; B_SIZE = 0; B_ADDR = 6'h09; B_REQ = 1;
    wait_ack(k);
    chk("arb1_a_ack", A_ACK, 1);
    chk("arb1_b_ack", B_ACK, 0);
    chk("arb1_a_rdata", A_RDATA, 32'h0000005A);
    wait_ack(k);
    chk("arb2_b_ack", B_ACK, 1);
    chk("arb2_a_ack", A_ACK, 0);
    chk("arb2_b_rdata", B_RDATA, 32'hFFFFFFC3);
    B_REQ = 0;
    wait_ack(k);
    chk("arb3_a_ack", A_ACK, 1);
    chk("arb3_b_ack", B_ACK, 0);
    A_REQ = 0;
    @(negedge CLK);

    xact("wr_word", 0, 1, 0, 2'd2, 6'h10, 32'h8899AABB, 5, 32'h0, 0, 4);
    chk("wr_word_mem", {mem[19], mem[18], mem[17], mem[16]}, 32'h8899AABB);
    xact("rd_b_s", 0, 0, 1, 2'd0, 6'h13, 32'h0, 3, 32'hFFFFFF88, 0, 1);
    xact("rd_b_u", 0, 0, 0, 2'd0, 6'h13, 32'h0, 3, 32'h00000088, 0, 1);
    xact("wr_half", 0, 1, 0, 2'd1, 6'h12, 32'hFFFF1234, 3, 32'h0, 0, 2);
    chk("wr_half_mem", {mem[19], mem[18], mem[17], mem[16]}, 32'h1234AABB);
    xact("rd_h_s", 0, 0, 1, 2'd1, 6'h12, 32'h0, 4, 32'h00001234, 0, 2);
    xact("rd_w_b", 1, 0, 0, 2'd2, 6'h10, 32'h0, 6, 32'h1234AABB, 0, 4);
    chk("a_rdata_kept", A_RDATA, 32'h00001234);
    xact("mis_h_b", 1, 0, 0, 2'd1, 6'h05, 32'h0, 1, 32'h0, 1, 0);
    xact("wr_h_b", 1, 1, 0, 2'd1, 6'h20, 32'h00008001, 3, 32'h0, 0, 2);
    xact("rd_h_neg", 1, 0, 1, 2'd1, 6'h20, 32'h0, 4, 32'hFFFF8001, 0, 2);
    xact("rd_sz3", 1, 0, 1, 2'd3, 6'h10, 32'h0, 6, 32'h1234AABB, 0, 4);
    xact("mis_w_a", 0, 1, 0, 2'd2, 6'h12, 32'h12345678, 1, 32'h0, 1, 0);
    chk("mis_w_mem", {mem[19], mem[18], mem[17], mem[16]}, 32'h1234AABB);
    xact("rd_h_s2", 0, 0, 1, 2'd1, 6'h12, 32'h0, 4, 32'h00001234, 0, 2);

    // reset during the second ISSUE cycle of a word write
    a_prev = A_RDATA;
    chk("pre_rst_rdata", a_prev, 32'h00001234);
    A_WE = 1; A_SIGNED = 0; A_SIZE = 2; A_ADDR = 6'h30; A_WDATA = 32'hDDCCBBAA; A_REQ = 1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    RST = 0;
    A_REQ = 0;
    chk("mid_rst_wen", WRITE_EN, 0);
    chk("mid_rst_a_rdata", A_RDATA, 0);
    chk("mid_rst_b_rdata", B_RDATA, 0);
    ack_seen = 0;
    repeat (4) begin
      @(negedge CLK);
      ack_seen = ack_seen | A_ACK | B_ACK;
    end
    chk("mid_rst_no_ack", ack_seen, 0);
    chk("mid_rst_mem", {mem[51], mem[50], mem[49], mem[48]}, 32'h0000BBAA);
    xact("post_rst_rd", 0, 0, 0, 2'd0, 6'h30, 32'h0, 3, 32'h000000AA, 0, 1);

    chk("monitor_viol", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
